// File: rtl/mult_unit.sv
// mult_unit: iterative 32x32 signed multiplier, radix-2 Booth, one step per clock.
//
// Ports:
//   clock        in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   start        in   single-cycle request; operands sampled on the same edge
//   multiplicand in   [31:0] signed operand A
//   multiplier   in   [31:0] signed operand B
//   product      out  [31:0] low half of A*B, 0 outside DONE
//   overflow     out  1 when the 64-bit product differs from sign-extended product
//   result_rdy   out  high in DONE
//   busy         out  high in BUSY
//   product_hi   out  [31:0] high half of A*B, 0 outside DONE (only with MULT_HI_EN)
//
// Configuration macro: MULT_HI_EN adds the product_hi port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | after reset, waiting for start
// ST_BUSY | one Booth step per edge, 32 edges
// ST_DONE | product/overflow valid and held; start restarts

module mult_unit (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic [31:0] product,
    output logic        overflow,
    output logic        result_rdy,
    output logic        busy
`ifdef MULT_HI_EN
    ,
    output logic [31:0] product_hi
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] m_q;
    logic [31:0] ac_q;
    logic [31:0] q_q;
    logic        q_m1_q;
    logic [4:0]  cnt_q;

    logic        accept;
    logic        last_step;
    logic [32:0] ac_ext;
    logic [32:0] m_ext;
    logic [32:0] sum;

    // start is ignored while a multiply is in flight
    assign accept    = start && (state_q != ST_BUSY);
    assign last_step = (cnt_q == 5'd31);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_BUSY;
            ST_BUSY: if (last_step) state_d = ST_DONE;
            ST_DONE: if (accept) state_d = ST_BUSY;
            default: state_d = ST_IDLE;
        endcase
    end

    // 33-bit add keeps the true sign of AC +/- M, which matters when
    // M = 0x80000000; the shift then takes the upper 32 bits of that sum.
    always_comb begin
        ac_ext = {ac_q[31], ac_q};
        m_ext  = {m_q[31], m_q};
        case ({q_q[0], q_m1_q})
            2'b01:   sum = ac_ext + m_ext;
            2'b10:   sum = ac_ext - m_ext;
            default: sum = ac_ext;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_q    <= 32'd0;
            ac_q   <= 32'd0;
            q_q    <= 32'd0;
            q_m1_q <= 1'b0;
            cnt_q  <= 5'd0;
        end else if (accept) begin
            m_q    <= multiplicand;
            ac_q   <= 32'd0;
            q_q    <= multiplier;
            q_m1_q <= 1'b0;
            cnt_q  <= 5'd0;
        end else if (state_q == ST_BUSY) begin
            ac_q   <= sum[32:1];
            q_q    <= {sum[0], q_q[31:1]};
            q_m1_q <= q_q[0];
            cnt_q  <= cnt_q + 5'd1;
        end
    end

    assign busy       = (state_q == ST_BUSY);
    assign result_rdy = (state_q == ST_DONE);
    assign product    = result_rdy ? q_q : 32'd0;
    assign overflow   = result_rdy && (ac_q != {32{q_q[31]}});

`ifdef MULT_HI_EN
    assign product_hi = result_rdy ? ac_q : 32'd0;
`endif

endmodule

// File: tb/tb_mult_unit.sv
// Testbench for mult_unit: directed vectors, expected results queued at issue
// time and checked by an independent monitor when result_rdy rises.

module tb_mult_unit;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [31:0] product;
    logic        overflow;
    logic        result_rdy;
    logic        busy;
`ifdef MULT_HI_EN
    logic [31:0] product_hi;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] prod;
        logic        ovf;
        logic [31:0] hi;
        int          acc_cyc;
    } exp_t;

    exp_t sb_q[$];

    mult_unit dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .overflow     (overflow),
        .result_rdy   (result_rdy),
        .busy         (busy)
`ifdef MULT_HI_EN
        ,
        .product_hi   (product_hi)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // monitor: one result per rising edge of result_rdy
    logic prev_rdy = 1'b0;
    always @(negedge clock) begin
        if (result_rdy && !prev_rdy) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got result_rdy=1 with product 0x%08h, expected no result", product);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("product", product, e.prod);
                check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
`ifdef MULT_HI_EN
                check("product_hi", product_hi, e.hi);
`endif
                check("latency", cyc - e.acc_cyc, 32);
            end
        end
        prev_rdy <= result_rdy;
    end

    // drive start for one cycle; caller is at a negedge
    task automatic pulse(input logic [31:0] a, input logic [31:0] b, input bit expect_accept,
                         input logic [31:0] p, input logic ovf, input logic [31:0] hi);
        exp_t e;
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        if (expect_accept) begin
            e.prod    = p;
            e.ovf     = ovf;
            e.hi      = hi;
            e.acc_cyc = cyc + 1;
            sb_q.push_back(e);
        end
        @(negedge clock);
        start        = 1'b0;
        multiplicand = 32'hDEAD_BEEF;
        multiplier   = 32'hCAFE_F00D;
    endtask

    task automatic wait_rdy(output int n);
        n = 0;
        while (!result_rdy && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!result_rdy) begin
            checks++;
            errors++;
            $display("FAIL wait_rdy: got no result_rdy within %0d cycles, expected one", n);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] p, input logic ovf, input logic [31:0] hi);
        int n;
        pulse(a, b, 1'b1, p, ovf, hi);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        wait_rdy(n);
        @(negedge clock);
    endtask

    initial begin
        int n;
        reset_n      = 1'b0;
        start        = 1'b0;
        multiplicand = 32'd0;
        multiplier   = 32'd0;
        repeat (3) @(negedge clock);
        check("rst_product", product, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_rdy", {31'd0, result_rdy}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // 3x7, with busy width counted directly
        pulse(32'd3, 32'd7, 1'b1, 32'd21, 1'b0, 32'd0);
        n = 1;
        while (busy && n < 100) begin
            @(negedge clock);
            if (busy) n++;
        end
        check("busy_cycles", n, 32);
        check("rdy_after_busy", {31'd0, result_rdy}, 32'd1);
        @(negedge clock);

        run_op(32'hFFFF_FFFB, 32'd6, 32'hFFFF_FFE2, 1'b0, 32'hFFFF_FFFF);
        run_op(32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1, 32'h0000_0000);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32'h0000_0000);
        run_op(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 32'h4000_0000);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000);
        run_op(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 32'h0000_0001);
        run_op(32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, 32'hFFFF_FFFF);
        run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h3FFF_FFFF);
        run_op(32'd5, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'hFFFF_FFFD);

        // start during BUSY is ignored; restart in the first DONE cycle
        pulse(32'd4, 32'd4, 1'b1, 32'd16, 1'b0, 32'd0);
        repeat (9) @(negedge clock);
        pulse(32'd9, 32'd9, 1'b0, 32'd0, 1'b0, 32'd0);
        wait_rdy(n);
        pulse(32'd9, 32'd9, 1'b1, 32'd81, 1'b0, 32'd0);
        check("rdy_drop_on_restart", {31'd0, result_rdy}, 32'd0);
        check("busy_on_restart", {31'd0, busy}, 32'd1);
        wait_rdy(n);
        @(negedge clock);

        // reset while DONE clears the held product immediately
        check("done_before_reset", {31'd0, result_rdy}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_done_product", product, 32'd0);
        check("rst_done_rdy", {31'd0, result_rdy}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // reset mid-BUSY, then no result ever appears
        pulse(32'd100, 32'd100, 1'b0, 32'd0, 1'b0, 32'd0);
        repeat (13) @(negedge clock);
        check("busy_before_reset", {31'd0, busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_rdy", {31'd0, result_rdy}, 32'd0);
        check("rst_mid_product", product, 32'd0);
        check("rst_mid_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (45) @(negedge clock);
        check("idle_after_reset_rdy", {31'd0, result_rdy}, 32'd0);
        check("idle_after_reset_busy", {31'd0, busy}, 32'd0);

        // recovery after reset
        run_op(32'd12, 32'hFFFF_FFF6, 32'hFFFF_FF88, 1'b0, 32'hFFFF_FFFF);

        repeat (2) @(negedge clock);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion by 200000, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mult_unit.md
# mult_unit

Iterative 32×32 signed multiplier using radix-2 Booth recoding. It is the multiply counterpart to the CPU's multi-cycle divider, and uses the same start/result-ready handshake so the execute stage can stall on either unit in the same way. It latches both operands on `start`, performs one Booth step per clock for 32 cycles, then holds the 32-bit product and an overflow flag until the next `start`.

## Interface
- No parameters. Width is fixed at 32.
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request; operands are sampled on the same edge.
- `multiplicand`  in  32  signed operand A.
- `multiplier`  in  32  signed operand B.
- `product`  out  32  low 32 bits of A×B; valid while `result_rdy`=1.
- `overflow`  out  1  1 when the 64-bit product ≠ sign-extension of `product`.
- `result_rdy`  out  1  high in DONE.
- `busy`  out  1  high in BUSY.
- `product_hi`  out  32  upper 32 bits of A×B; present only with `MULT_HI_EN`.

## Operation
- **State machine: IDLE, BUSY, DONE.**
  - IDLE→BUSY, and DONE→BUSY, on a clock edge with `start`=1. On that edge: M←`multiplicand`; accumulator AC←0; Q←`multiplier`; Q₋₁←0; step counter←0.
  - BUSY, each edge:
    - Inspect {Q[0],Q₋₁}: 01 → AC←AC+M; 10 → AC←AC−M; 00/11 → no add.
    - Then arithmetic-shift {AC,Q,Q₋₁} right by 1, with AC[31] replicated.
    - Counter increments.
    - The edge that completes step 31 moves to DONE.
  - DONE: result registers hold. `result_rdy`=1 until the next accepted `start`.
- **Start rules.**
  - `start` is ignored while in BUSY: no restart, and operands are not resampled.
  - `start` in DONE restarts on that edge. `result_rdy` drops the next cycle.
- **Result.**
  - {AC,Q} is the full two's-complement 64-bit product. `product`=Q and `product_hi`=AC.
  - `overflow` = (AC ≠ {32{Q[31]}}). It is computed combinationally from the registered AC and Q, and is masked to 0 unless in DONE.
  - `product` is driven as 0 outside DONE, so stale partial values are never visible.
- **Arithmetic.**
  - AC add/subtract is 32-bit.
  - The M=0x80000000 case must be exact. Use a 33-bit AC internally, or equivalently keep the sign of the add result correct before the shift.
- **Reset.** Asserting `reset_n`=0 at any time, including mid-BUSY, immediately forces:
  - state IDLE;
  - AC, Q, Q₋₁, M, counter = 0;
  - `result_rdy`=0, `busy`=0, `product`=0, `overflow`=0, `product_hi`=0.

## Timing
- Call the edge that accepts `start` E0.
  - `busy`=1 after E0.
  - The 32nd BUSY edge is E32. `result_rdy`=1 and outputs are valid after E32.
  - Latency from the accepting edge to first valid cycle: 32 clocks.
- Back-to-back operation: `start` asserted in the first DONE cycle gives a throughput of one result per 33 clocks.
- All outputs are registered or derived combinationally from registers only. No input-to-output combinational path.
- Reset values of all outputs are 0.

## Configuration
- **`MULT_HI_EN` defined:**
  - `product_hi` port exists and shows AC in DONE (0 otherwise).
  - `overflow` is still provided.
- **`MULT_HI_EN` undefined:**
  - `product_hi` port is absent. AC is still kept internally for the overflow check.
  - Port list otherwise identical; timing unchanged.

## Test plan
- Reset, then `start` with 3×7 → `busy` for 32 cycles; `result_rdy`=1 exactly 32 clocks after the accepting edge; `product`=21, `overflow`=0, `product_hi`=0.
- −5×6 → `product`=0xFFFFFFE2, `overflow`=0, `product_hi`=0xFFFFFFFF.
- 0x7FFFFFFF×2 → `product`=0xFFFFFFFE, `overflow`=1, `product_hi`=0. Then 0x80000000×0xFFFFFFFF → `product`=0x80000000, `overflow`=1, `product_hi`=0.
- `start` with 4×4, then `start` pulsed at cycle 10 with 9×9 → cycle-10 pulse ignored; result 16 at cycle 32. Then `start` 9×9 in the first DONE cycle → `result_rdy` drops next cycle, 81 appears 32 clocks later.
- `reset_n` low at cycle 15 of 100×100 → all outputs 0 immediately, state IDLE. After release with no `start`, `result_rdy` stays 0 indefinitely.
- 0x80000000×0x80000000 → `product`=0, `overflow`=1, `product_hi`=0x40000000.
